// File: rtl/vending_machine.sv
// vending_machine: 5/10-unit coin vending controller; in clk rst item[1:0] five_in ten_in, out dispense change
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] item,
  input  logic       five_in,
  input  logic       ten_in,
  output logic       dispense,
  output logic       change
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t     state_q, state_d;
  logic [5:0] credit_q, credit_d, price_q, price_d, cur_price, coin, sum;
  logic       dispense_q, dispense_d, change_q, change_d, five_q, five_d, ten_q, ten_d;
  logic       five_ev, ten_ev, accept;
  always_comb begin
    five_ev    = five_in & ~five_q;
    ten_ev     = ten_in & ~ten_q;
    coin       = (five_ev ? 6'd5 : 6'd0) + (ten_ev ? 6'd10 : 6'd0);
    cur_price  = state_q == COLLECT ? price_q : item == 2'b01 ? 6'd15 : item == 2'b10 ? 6'd25 : 6'd35;
    sum        = (state_q == COLLECT ? credit_q : 6'd0) + coin;
    accept     = (five_ev | ten_ev) & (state_q == COLLECT | item != 2'b00);
    five_d     = five_in;
    ten_d      = ten_in;
    state_d    = state_q;
    credit_d   = credit_q;
    price_d    = price_q;
    dispense_d = dispense_q;
    change_d   = change_q;
    if (accept) begin
      price_d    = cur_price;
      dispense_d = sum >= cur_price;
      change_d   = sum > cur_price;
      credit_d   = sum >= cur_price ? 6'd0 : sum;
      state_d    = sum >= cur_price ? IDLE : COLLECT;
    end
  end
  always_ff @(posedge clk) begin
    five_q <= five_d;
    ten_q  <= ten_d;
    if (rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      price_q    <= '0;
      dispense_q <= 1'b0;
      change_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      price_q    <= price_d;
      dispense_q <= dispense_d;
      change_q   <= change_d;
    end
  end
  assign dispense = dispense_q;
  assign change   = change_q;
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: table-driven directed checks of vending_machine
module tb_vending_machine;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] item = 2'b00;
  logic       five_in = 1'b0;
  logic       ten_in = 1'b0;
  logic       dispense, change;
  int         tests = 0;
  int         fails = 0;
  typedef struct {
    logic       rst;
    logic [1:0] item;
    logic       five;
    logic       ten;
    int         n;
    logic       d;
    logic       c;
  } vec_t;
  vec_t vq[$];
  vending_machine dut (
    .clk(clk), .rst(rst), .item(item), .five_in(five_in), .ten_in(ten_in),
    .dispense(dispense), .change(change)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic [1:0] it, input logic f, input logic t,
                     input int n, input logic d, input logic c);
    vec_t v;
    v.rst = r; v.item = it; v.five = f; v.ten = t; v.n = n; v.d = d; v.c = c;
    vq.push_back(v);
  endtask
  task automatic step(input string name, input logic d, input logic c);
    @(posedge clk);
    #1;
    tests++;
    if (dispense !== d || change !== c) begin
      fails++;
      $display("FAIL %s: dispense=%b change=%b, expected dispense=%b change=%b", name, dispense, change, d, c);
    end
  endtask
  initial begin
    add(1,0,0,0,2,0,0);
    add(0,1,1,0,5,0,0); add(0,1,0,0,1,0,0); add(0,1,0,1,5,1,0); add(0,1,0,0,3,1,0);
    add(0,1,0,1,1,0,0); add(0,1,0,0,1,0,0); add(0,1,0,1,1,1,1); add(0,1,0,0,1,1,1);
    add(1,2,0,0,1,0,0); add(0,2,1,0,1,0,0); add(0,2,0,0,1,0,0); add(0,2,0,1,1,0,0);
    add(0,2,0,0,1,0,0); add(0,2,0,1,1,1,0); add(0,2,0,0,1,1,0);
    add(1,1,0,0,1,0,0); add(0,1,1,0,20,0,0); add(0,1,0,0,1,0,0); add(0,1,1,0,1,0,0);
    add(0,1,0,0,1,0,0); add(0,1,0,1,1,1,1); add(0,1,0,0,1,1,1);
    add(0,1,1,1,1,1,0); add(0,1,0,0,1,1,0);
    add(0,0,0,1,1,1,0); add(0,0,0,0,1,1,0); add(0,1,1,0,1,0,0); add(0,1,0,0,1,0,0);
    add(0,1,0,1,1,1,0); add(0,1,0,0,1,1,0);
    add(1,3,0,0,1,0,0); add(0,3,0,1,1,0,0); add(0,3,0,0,1,0,0); add(1,3,0,0,1,0,0);
    add(0,3,0,1,1,0,0); add(0,3,0,0,1,0,0); add(0,3,0,1,1,0,0); add(0,3,0,0,1,0,0);
    add(0,3,0,1,1,0,0); add(0,3,0,0,1,0,0); add(0,3,0,1,1,1,1); add(0,3,0,0,1,1,1);
    add(1,1,0,1,1,0,0); add(0,1,0,1,2,0,0); add(0,1,0,0,1,0,0); add(0,1,1,0,1,0,0);
    add(0,1,0,0,1,0,0); add(0,1,0,1,1,1,0);
    add(1,3,0,0,1,0,0); add(0,3,0,1,1,0,0); add(0,3,0,0,1,0,0); add(0,1,0,1,1,0,0);
    add(0,1,0,0,1,0,0); add(0,1,0,1,1,0,0); add(0,1,0,0,1,0,0); add(0,1,1,0,1,1,0);
    add(0,1,0,0,1,1,0);
    foreach (vq[i]) begin
      rst = vq[i].rst; item = vq[i].item; five_in = vq[i].five; ten_in = vq[i].ten;
      for (int k = 0; k < vq[i].n; k++) step($sformatf("vec%0d.%0d", i, k), vq[i].d, vq[i].c);
    end
    rst = 1'b1; item = 2'b11; five_in = 1'b0; ten_in = 1'b0;
    step("seq35_rst", 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ten_in = 1'b1;
      step($sformatf("seq35_coin%0d", k), k == 3, k == 3);
      ten_in = 1'b0;
      step($sformatf("seq35_idle%0d", k), k == 3, k == 3);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
